mem_x128_arbiter: RTL

//  Two-port round-robin arbiter that shares one 128-bit memory port
//  (mem_req_16B_t / mem_resp_16B_t, val/rdy) between two requesters
//  (port 0 = icache, port 1 = dcache). Allows one outstanding transaction.

---
 rtl/mem_x128_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_x128_arbiter.sv
// Round-robin arbiter sharing one 128-bit memory port between icache (port 0)
// and dcache (port 1), with one outstanding transaction and response steering.
package mem_x128_pkg;
   typedef struct packed {
      logic         typ;     // 0 = read, 1 = write
      logic [7:0]   opaque;
      logic [31:0]  addr;
      logic [127:0] data;
   } mem_req_16B_t;

   typedef struct packed {
      logic         typ;
      logic [7:0]   opaque;
      logic [127:0] data;
   } mem_resp_16B_t;
endpackage

module mem_x128_arbiter
   import mem_x128_pkg::*;
#(
   parameter logic        RR_INIT = 1'b0,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  mem_req_16B_t  p0_req_msg,
   input  logic          p0_req_val,
   output logic          p0_req_rdy,
   output mem_resp_16B_t p0_resp_msg,
   output logic          p0_resp_val,
   input  logic          p0_resp_rdy,
   input  mem_req_16B_t  p1_req_msg,
   input  logic          p1_req_val,
   output logic          p1_req_rdy,
   output mem_resp_16B_t p1_resp_msg,
   output logic          p1_resp_val,
   input  logic          p1_resp_rdy,
   output mem_req_16B_t  mem_req_msg,
   output logic          mem_req_val,
   input  logic          mem_req_rdy,
   input  mem_resp_16B_t mem_resp_msg,
   input  logic          mem_resp_val,
   output logic          mem_resp_rdy,
   output logic          busy_o,
   output logic          timeout_o,
   output logic          stray_o
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             prio_q, prio_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic             stray_q, stray_d;
   logic             gnt_val, gnt, resp_rdy;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      prio_d      = prio_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      stray_d     = stray_q;
      gnt_val     = 1'b0;
      gnt         = prio_q;
      resp_rdy    = 1'b0;
      p0_req_rdy  = 1'b0;
      p1_req_rdy  = 1'b0;
      p0_resp_msg = '0;
      p1_resp_msg = '0;
      p0_resp_val = 1'b0;
      p1_resp_val = 1'b0;
      mem_req_msg = p0_req_msg;
      mem_req_val = 1'b0;

      case (state_q)
         IDLE: begin
            if (prio_q ? p1_req_val : p0_req_val) begin
               gnt_val = 1'b1;
               gnt     = prio_q;
            end else if (prio_q ? p0_req_val : p1_req_val) begin
               gnt_val = 1'b1;
               gnt     = ~prio_q;
            end
            mem_req_msg = (gnt_val && gnt) ? p1_req_msg : p0_req_msg;
            mem_req_val = p0_req_val | p1_req_val;
            p0_req_rdy  = gnt_val && !gnt && mem_req_rdy;
            p1_req_rdy  = gnt_val &&  gnt && mem_req_rdy;
            // Responses arriving with nothing outstanding are accepted and dropped.
            resp_rdy    = 1'b1;
            if (mem_resp_val) stray_d = 1'b1;
            if (gnt_val && mem_req_rdy) begin
               state_d    = WAIT;
               owner_d    = gnt;
               prio_d     = ~gnt;
               wait_cnt_d = '0;
            end
         end
         WAIT: begin
            if (owner_q) begin
               p1_resp_msg = mem_resp_msg;
               p1_resp_val = mem_resp_val;
               resp_rdy    = p1_resp_rdy;
            end else begin
               p0_resp_msg = mem_resp_msg;
               p0_resp_val = mem_resp_val;
               resp_rdy    = p0_resp_rdy;
            end
            wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if ((TIMEOUT != 0) && (wait_cnt_d == TO_CNT)) timeout_d = 1'b1;
            if (mem_resp_val && resp_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_resp_rdy = resp_rdy;
   assign busy_o       = (state_q == WAIT);
   assign timeout_o    = timeout_q;
   assign stray_o      = stray_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         prio_q     <= RR_INIT;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
         stray_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         prio_q     <= prio_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
         stray_q    <= stray_d;
      end
   end

endmodule
